// File: rtl/median_select_ctrl.sv
// ---------------------------------------------------------------------------
// median_select_ctrl
//   Quickselect round scheduler for the median filter's partition datapath.
//   A selection starts over the window buffer. Each round it asks the send
//   stage to stream one buffer (input / less / greater), waits for the
//   partition counts, then either descends into a sub-buffer or finishes
//   with the pivot as the median.
//
//   Optional build macro: MEDIAN_SUM_CHECK_EN. When it is defined, every
//   round's counts must satisfy lt+eq+gt == current size; a mismatch aborts
//   the selection with err.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle request to begin (ignored unless idle)
//   start_size          initial buffer occupancy
//   start_pos           0-based rank to select
//   busy                high whenever not idle
//   send_req            round request to the send stage
//   send_buff_size      size of the buffer sent this round
//   send_sel            0 = input, 1 = less, 2 = greater buffer
//   send_median_pos     rank within the current buffer
//   sending             send stage busy; acknowledges send_req
//   res_valid           1-cycle pulse: partition results valid
//   res_pivot           pivot used this round
//   res_cnt_lt/eq/gt    partition counts
//   done                1-cycle pulse; median_value valid
//   median_value        selected value, held until the next done
//   err                 1-cycle pulse; selection aborted
//   round_cnt           rounds issued in the current or last selection
// ---------------------------------------------------------------------------
module median_select_ctrl #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int DATA_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] start_size,
  input  logic [BUFF_SIZE_BIT-1:0] start_pos,
  output logic                     busy,
  output logic                     send_req,
  output logic [BUFF_SIZE_BIT-1:0] send_buff_size,
  output logic [1:0]               send_sel,
  output logic [BUFF_SIZE_BIT-1:0] send_median_pos,
  input  logic                     sending,
  input  logic                     res_valid,
  input  logic [DATA_W-1:0]        res_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] res_cnt_lt,
  input  logic [BUFF_SIZE_BIT-1:0] res_cnt_eq,
  input  logic [BUFF_SIZE_BIT-1:0] res_cnt_gt,
  output logic                     done,
  output logic [DATA_W-1:0]        median_value,
  output logic                     err,
  output logic [BUFF_SIZE_BIT-1:0] round_cnt
);

  // One extra bit so lt+eq and the rank comparisons cannot wrap.
  localparam int CW = BUFF_SIZE_BIT + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RES, S_DECIDE, S_DONE, S_ERR
  } state_t;

  state_t                   state_q, state_d;
  logic [BUFF_SIZE_BIT-1:0] cur_size_q, cur_size_d;
  logic [BUFF_SIZE_BIT-1:0] cur_pos_q, cur_pos_d;
  logic [1:0]               sel_q, sel_d;
  logic [BUFF_SIZE_BIT-1:0] round_q, round_d;
  logic [DATA_W-1:0]        med_q, med_d;
  logic [DATA_W-1:0]        piv_q, piv_d;
  logic [BUFF_SIZE_BIT-1:0] lt_q, lt_d;
  logic [BUFF_SIZE_BIT-1:0] eq_q, eq_d;
  logic [BUFF_SIZE_BIT-1:0] gt_q, gt_d;

  logic [CW-1:0] lt_w, le_w, pos_w, rem_w;
  logic          round_lim;

  assign lt_w      = {1'b0, lt_q};
  assign le_w      = {1'b0, lt_q} + {1'b0, eq_q};
  assign pos_w     = {1'b0, cur_pos_q};
  assign rem_w     = pos_w - le_w;
  assign round_lim = (round_q == BUFF_SIZE_BIT'(BUFF_SIZE));

`ifdef MEDIAN_SUM_CHECK_EN
  // Three full-scale counts need two extra bits.
  localparam int SW = BUFF_SIZE_BIT + 2;
  logic [SW-1:0] sum_w;
  logic          sum_bad;
  assign sum_w   = {2'b00, lt_q} + {2'b00, eq_q} + {2'b00, gt_q};
  assign sum_bad = (sum_w != {2'b00, cur_size_q});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_size_q <= '0;
      cur_pos_q  <= '0;
      sel_q      <= '0;
      round_q    <= '0;
      med_q      <= '0;
      piv_q      <= '0;
      lt_q       <= '0;
      eq_q       <= '0;
      gt_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_size_q <= cur_size_d;
      cur_pos_q  <= cur_pos_d;
      sel_q      <= sel_d;
      round_q    <= round_d;
      med_q      <= med_d;
      piv_q      <= piv_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
      gt_q       <= gt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_size_d = cur_size_q;
    cur_pos_d  = cur_pos_q;
    sel_d      = sel_q;
    round_d    = round_q;
    med_d      = med_q;
    piv_d      = piv_q;
    lt_d       = lt_q;
    eq_d       = eq_q;
    gt_d       = gt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_size == '0 || start_pos >= start_size) begin
            state_d = S_ERR;
          end else begin
            cur_size_d = start_size;
            cur_pos_d  = start_pos;
            sel_d      = 2'd0;
            round_d    = '0;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (sending) begin
          round_d = round_q + BUFF_SIZE_BIT'(1);
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          piv_d   = res_pivot;
          lt_d    = res_cnt_lt;
          eq_d    = res_cnt_eq;
          gt_d    = res_cnt_gt;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (pos_w < lt_w) begin
          if (lt_q == '0 || round_lim) begin
            state_d = S_ERR;
          end else begin
            cur_size_d = lt_q;
            sel_d      = 2'd1;
            state_d    = S_ISSUE;
          end
        end else if (pos_w < le_w) begin
          med_d   = piv_q;
          state_d = S_DONE;
        end else begin
          if (gt_q == '0 || round_lim) begin
            state_d = S_ERR;
          end else begin
            cur_pos_d  = rem_w[BUFF_SIZE_BIT-1:0];
            cur_size_d = gt_q;
            sel_d      = 2'd2;
            state_d    = S_ISSUE;
          end
        end
`ifdef MEDIAN_SUM_CHECK_EN
        // Inconsistent counts override every decision above.
        if (sum_bad) begin
          cur_size_d = cur_size_q;
          cur_pos_d  = cur_pos_q;
          sel_d      = sel_q;
          med_d      = med_q;
          state_d    = S_ERR;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign send_req        = (state_q == S_ISSUE);
  assign done            = (state_q == S_DONE);
  assign err             = (state_q == S_ERR);
  assign send_buff_size  = cur_size_q;
  assign send_median_pos = cur_pos_q;
  assign send_sel        = sel_q;
  assign median_value    = med_q;
  assign round_cnt       = round_q;

endmodule

// File: tb/tb_median_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_median_select_ctrl
//   Directed bench for median_select_ctrl with hand-computed expectations.
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_median_select_ctrl;

  localparam int BSB = 6;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [BSB-1:0] start_size, start_pos;
  logic           busy, send_req;
  logic [BSB-1:0] send_buff_size, send_median_pos;
  logic [1:0]     send_sel;
  logic           sending, res_valid;
  logic [DW-1:0]  res_pivot;
  logic [BSB-1:0] res_cnt_lt, res_cnt_eq, res_cnt_gt;
  logic           done, err;
  logic [DW-1:0]  median_value;
  logic [BSB-1:0] round_cnt;

  int n_chk = 0;
  int n_err = 0;

  median_select_ctrl #(.BUFF_SIZE(32), .BUFF_SIZE_BIT(BSB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_size(start_size), .start_pos(start_pos),
    .busy(busy), .send_req(send_req), .send_buff_size(send_buff_size),
    .send_sel(send_sel), .send_median_pos(send_median_pos),
    .sending(sending), .res_valid(res_valid), .res_pivot(res_pivot),
    .res_cnt_lt(res_cnt_lt), .res_cnt_eq(res_cnt_eq), .res_cnt_gt(res_cnt_gt),
    .done(done), .median_value(median_value), .err(err), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sel(input int size, input int pos);
    start      = 1'b1;
    start_size = BSB'(size);
    start_pos  = BSB'(pos);
    step();
    start = 1'b0;
  endtask

  task automatic ack();
    sending = 1'b1;
    step();
    sending = 1'b0;
  endtask

  // Leaves the DUT in DECIDE.
  task automatic give_res(input int lt, input int eq, input int gt, input int piv);
    res_valid  = 1'b1;
    res_cnt_lt = BSB'(lt);
    res_cnt_eq = BSB'(eq);
    res_cnt_gt = BSB'(gt);
    res_pivot  = DW'(piv);
    step();
    res_valid = 1'b0;
  endtask

  task automatic chk_issue(input string tag, input int sel, input int size, input int pos);
    chk({tag, "_req"},  send_req, 1);
    chk({tag, "_sel"},  send_sel, sel);
    chk({tag, "_size"}, send_buff_size, size);
    chk({tag, "_pos"},  send_median_pos, pos);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_size = '0; start_pos = '0;
    sending = 1'b0; res_valid = 1'b0; res_pivot = '0;
    res_cnt_lt = '0; res_cnt_eq = '0; res_cnt_gt = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_req", send_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_med", median_value, 0);
    chk("rst_round", round_cnt, 0);
    chk("rst_size", send_buff_size, 0);
    rst_n = 1'b1;
    step();

    // Single round: size 9, rank 4 -> pivot is the median.
    begin_sel(9, 4);
    chk_issue("r1_issue", 0, 9, 4);
    chk("r1_busy", busy, 1);
    ack();
    chk("r1_req_drop", send_req, 0);
    chk("r1_round", round_cnt, 1);
    give_res(4, 1, 4, 8'h80);
    chk("r1_done_early", done, 0);
    step();
    chk("r1_done", done, 1);
    chk("r1_med", median_value, 8'h80);
    step();
    chk("r1_done_pulse", done, 0);
    chk("r1_idle", busy, 0);
    chk("r1_med_hold", median_value, 8'h80);

    // Descend into the less buffer, then finish.
    begin_sel(9, 2);
    ack();
    give_res(5, 1, 3, 8'h50);
    step();
    chk_issue("lt_issue", 1, 5, 2);
    ack();
    chk("lt_round", round_cnt, 2);
    give_res(1, 2, 2, 8'h30);
    step();
    chk("lt_done", done, 1);
    chk("lt_med", median_value, 8'h30);
    chk("lt_round_end", round_cnt, 2);
    step();

    // Descend into the greater buffer: rank 7 - (3+2) = 2.
    begin_sel(9, 7);
    ack();
    give_res(3, 2, 4, 8'h60);
    step();
    chk_issue("gt_issue", 2, 4, 2);
    ack();
    give_res(0, 4, 0, 8'h90);
    step();
    chk("gt_done", done, 1);
    chk("gt_med", median_value, 8'h90);
    step();

    // Handshake: request held while sending stays low; stray res_valid ignored.
    begin_sel(5, 0);
    for (int i = 0; i < 10; i++) begin
      res_valid = (i == 3);
      step();
      chk_issue("hs_hold", 0, 5, 0);
    end
    res_valid = 1'b0;
    ack();
    chk("hs_drop", send_req, 0);
    chk("hs_round", round_cnt, 1);
    give_res(0, 1, 4, 8'h11);
    step();
    chk("hs_done", done, 1);
    chk("hs_med", median_value, 8'h11);
    step();

    // Errors at start.
    begin_sel(0, 0);
    chk("e0_err", err, 1);
    chk("e0_busy", busy, 1);
    step();
    chk("e0_err_pulse", err, 0);
    chk("e0_idle", busy, 0);
    chk("e0_med", median_value, 8'h11);
    begin_sel(9, 9);
    chk("epos_err", err, 1);
    step();

`ifdef MEDIAN_SUM_CHECK_EN
    // Inconsistent counts abort the selection.
    begin_sel(9, 4);
    ack();
    give_res(3, 1, 3, 8'hEE);
    step();
    chk("sum_err", err, 1);
    chk("sum_med", median_value, 8'h11);
    step();
`endif

    // Reset while waiting for results, then a clean selection.
    begin_sel(9, 4);
    ack();
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_round", round_cnt, 0);
    chk("ar_med", median_value, 0);
    res_valid = 1'b1; res_cnt_lt = 6'd4; res_cnt_eq = 6'd1; res_cnt_gt = 6'd4;
    step();
    res_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("ar_no_done", done, 0);
    chk("ar_idle", busy, 0);
    begin_sel(9, 4);
    chk_issue("ar_issue", 0, 9, 4);
    ack();
    chk("ar_round1", round_cnt, 1);
    give_res(4, 1, 4, 8'h80);
    step();
    chk("ar_done", done, 1);
    chk("ar_med2", median_value, 8'h80);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
